ex_div: RTL
===========

Name: ex_div

Overview:
- Execute stage, directly downstream of the decode stage (fed via the id/ex pipeline register).
- Consumes aluop/alusel, the two 32-bit operands, and the destination/write-enable from decode.
- Produces the GPR writeback triple and HI/LO writes.
- Single-cycle ops complete combinationally; DIV/DIVU run on an iterative radix-2 divider, and a stall request holds the pipeline until the quotient is ready.

Parameters:
- DATA_W, 32, operand/result width
- DIV_CYCLES, 32, iterations of the restoring divider; equals DATA_W

Ports:
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- aluop_i  in  8  operation code from decode
- alusel_i  in  3  result class from decode
- reg1_i  in  32  operand 1
- reg2_i  in  32  operand 2
- wd_i  in  5  destination register
- wreg_i  in  1  GPR write enable
- annul_i  in  1  flush from pipeline control; aborts a divide in progress
- wd_o  out  5  destination register to mem stage
- wreg_o  out  1  GPR write enable to mem stage
- wdata_o  out  32  GPR write data
- whilo_o  out  1  HI/LO write enable
- hi_o  out  32  remainder
- lo_o  out  32  quotient
- stallreq_o  out  1  request to hold pc/if_id/id_ex

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high.
- Reset:
  - Divider FSM goes to IDLE; counter and internal state are cleared.
  - While rst=1, all outputs are 0, including stallreq_o=0 and whilo_o=0.
- Result classes (combinational, 0-cycle latency):
  - LOGIC: OR, AND, XOR, NOR.
  - SHIFT: SLL, SRL, SRA. Shift amount is reg1_i[4:0]; reg2_i is shifted.
  - ARITH: ADD, ADDU, SUB, SUBU, SLT, SLTU. Arithmetic is mod 2^32.
  - NOP class: wdata_o=0.
- Overflow on ADD/SUB:
  - Detected as operand signs equal (for SUB, against the negated operand) and result sign differing.
  - On overflow, force wreg_o=0. ADDU/SUBU never suppress the write.
- SLT is a signed compare; SLTU is unsigned. The result is zero-extended 0/1.
- wd_o=wd_i always. wreg_o=wreg_i except on overflow suppression.
- DIV/DIVU write HI/LO only; wreg_i is 0 for these from decode.
- Divider FSM states: IDLE, ON, END.
  - IDLE + div op + annul_i=0 + divisor≠0: latch |dividend| and |divisor| (signed) or raw values (unsigned); record the result signs; go to ON with count=0.
  - IDLE + div op + divisor=0: go to END with quotient=0, remainder=0.
  - ON: one restoring subtract-shift per cycle. After the 32nd iteration go to END.
  - END: present the result. Signed: quotient negated iff operand signs differ; remainder takes the dividend's sign. Unconditionally go to IDLE.
  - annul_i=1 in any state: go to IDLE next edge. whilo_o stays 0 that cycle.
- stallreq_o = div op present AND state≠END. whilo_o = 1 only in END (and only for a div op).
- Timing, normal divide: div op appears in cycle 0. stallreq_o is 1 for cycles 0..32. Cycle 33 is END: stallreq_o=0, whilo_o=1, and the id_ex/ex_mem registers advance at that edge. Total 34 cycles.
- Timing, divide by zero: cycle 0 stalls; cycle 1 is END with a result of 0.
- Back-to-back divides: the second starts from IDLE the cycle after END; there is no overlap.
- Non-div op while the FSM is not IDLE cannot occur, because the pipeline is held. If it does, the FSM still finishes and the result is discarded.

Decomposition:
- Shared defines:
  - aluop codes: EXE_AND/OR/XOR/NOR/SLL/SRL/SRA/ADD/ADDU/SUB/SUBU/SLT/SLTU/DIV/DIVU_OP.
  - alusel codes: EXE_RES_NOP/LOGIC/SHIFT/ARITH.
  - Existing RstEnable, ZeroWord, RegBus, AluOpBus, AluSelBus, RegAddrBus.
  - Divider state encodings DivFree/DivOn/DivEnd.
- Sub-module `div`:
  - Inputs: clk, rst, signed_div, opdata1, opdata2, start, annul.
  - Outputs: result[63:0], ready.
  - Contains the FSM and iteration.
  - ex_div keeps the ALU muxing and the stall/whilo glue.

Test Plan:
- OR reg1=0x0000_1100, reg2=0x0000_0020, alusel LOGIC, wreg=1, wd=3 -> same cycle: wdata_o=0x0000_1120, wreg_o=1, wd_o=3, stallreq_o=0.
- SRA reg1=4, reg2=0x8000_0000 -> wdata_o=0xF800_0000. SLTU 1 vs 0xFFFF_FFFF -> wdata_o=1. SLT same operands -> wdata_o=0.
- ADD 0x7FFF_FFFF+1 -> wreg_o=0. ADDU same operands -> wreg_o=1, wdata_o=0x8000_0000.
- DIV reg1=-7 (0xFFFF_FFF9), reg2=2 -> stallreq_o=1 for 33 cycles. Cycle 33: whilo_o=1, lo_o=0xFFFF_FFFD, hi_o=0xFFFF_FFFF.
- DIVU 100/0 -> stallreq_o=1 for cycle 0 only. Cycle 1: lo_o=0, hi_o=0, whilo_o=1.
- DIVU 100/7 with annul_i pulsed at cycle 10 -> FSM IDLE at cycle 11, whilo_o never 1. A following DIVU 100/7 yields lo_o=14, hi_o=2 at its cycle 33. Repeat with rst at cycle 5 -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/ex_div_pkg.sv
// Shared types and codes for the execute stage with iterative divider.
// Holds bus widths, aluop/alusel encodings, divider state encoding and
// a small helper that classifies divide opcodes.
package ex_div_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned DIV_CYCLES = DATA_W;
    localparam int unsigned CNT_W      = $clog2(DIV_CYCLES);
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ALUOP_W    = 8;
    localparam int unsigned ALUSEL_W   = 3;

    typedef logic [DATA_W-1:0]     reg_bus_t;
    typedef logic [ALUOP_W-1:0]    alu_op_t;
    typedef logic [ALUSEL_W-1:0]   alu_sel_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam logic     RST_ENABLE = 1'b1;
    localparam reg_bus_t ZERO_WORD  = '0;

    // aluop codes
    localparam alu_op_t EXE_NOP_OP  = 8'b0000_0000;
    localparam alu_op_t EXE_AND_OP  = 8'b0010_0100;
    localparam alu_op_t EXE_OR_OP   = 8'b0010_0101;
    localparam alu_op_t EXE_XOR_OP  = 8'b0010_0110;
    localparam alu_op_t EXE_NOR_OP  = 8'b0010_0111;
    localparam alu_op_t EXE_SLL_OP  = 8'b0111_1100;
    localparam alu_op_t EXE_SRL_OP  = 8'b0000_0010;
    localparam alu_op_t EXE_SRA_OP  = 8'b0000_0011;
    localparam alu_op_t EXE_ADD_OP  = 8'b0010_0000;
    localparam alu_op_t EXE_ADDU_OP = 8'b0010_0001;
    localparam alu_op_t EXE_SUB_OP  = 8'b0010_0010;
    localparam alu_op_t EXE_SUBU_OP = 8'b0010_0011;
    localparam alu_op_t EXE_SLT_OP  = 8'b0010_1010;
    localparam alu_op_t EXE_SLTU_OP = 8'b0010_1011;
    localparam alu_op_t EXE_DIV_OP  = 8'b0001_1010;
    localparam alu_op_t EXE_DIVU_OP = 8'b0001_1011;

    // alusel result classes
    localparam alu_sel_t EXE_RES_NOP   = 3'b000;
    localparam alu_sel_t EXE_RES_LOGIC = 3'b001;
    localparam alu_sel_t EXE_RES_SHIFT = 3'b010;
    localparam alu_sel_t EXE_RES_ARITH = 3'b100;

    typedef enum logic [1:0] {
        DIV_FREE = 2'b00,
        DIV_ON   = 2'b01,
        DIV_END  = 2'b10
    } div_state_e;

    function automatic logic is_div_op(input alu_op_t op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/ex_div_if.sv
// id/ex -> ex -> ex/mem signal bundle for the execute stage.
// master: decode/pipeline-control side (drives operation, reads results).
// slave : execute stage (reads operation, drives writeback/HI-LO/stall).
interface ex_div_if;
    import ex_div_pkg::*;

    alu_op_t   aluop_i;
    alu_sel_t  alusel_i;
    reg_bus_t  reg1_i;
    reg_bus_t  reg2_i;
    reg_addr_t wd_i;
    logic      wreg_i;
    logic      annul_i;

    reg_addr_t wd_o;
    logic      wreg_o;
    reg_bus_t  wdata_o;
    logic      whilo_o;
    reg_bus_t  hi_o;
    reg_bus_t  lo_o;
    logic      stallreq_o;

    modport master (
        output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, annul_i,
        input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );

    modport slave (
        input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, annul_i,
        output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );

endinterface

// File: rtl/ex_div_div.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Ports: clk, rst (sync, active-high); signed_div selects DIV vs DIVU;
// opdata1 dividend, opdata2 divisor; start requests a divide while idle;
// annul aborts back to idle. result = {remainder, quotient}, valid while
// ready is high (one cycle, the END state).
module ex_div_div
    import ex_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div,
    input  reg_bus_t    opdata1,
    input  reg_bus_t    opdata2,
    input  logic        start,
    input  logic        annul,
    output logic [2*DATA_W-1:0] result,
    output logic        ready
);

    div_state_e       state_q, state_d;
    reg_bus_t         rem_q;
    reg_bus_t         quo_q;
    reg_bus_t         dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_q_q;
    logic             neg_r_q;

    logic             last_iter;
    logic             div_zero;
    logic [DATA_W:0]  rem_shift;
    logic [DATA_W:0]  diff;
    reg_bus_t         rem_nx;
    reg_bus_t         quo_nx;
    reg_bus_t         q_fix;
    reg_bus_t         r_fix;
    reg_bus_t         abs1;
    reg_bus_t         abs2;

    assign last_iter = (cnt_q == CNT_W'(DIV_CYCLES - 1));
    assign div_zero  = (opdata2 == ZERO_WORD);

    // State register
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) state_q <= DIV_FREE;
        else                   state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_FREE: begin
                if (start && !annul) state_d = div_zero ? DIV_END : DIV_ON;
            end
            DIV_ON: begin
                if (annul)          state_d = DIV_FREE;
                else if (last_iter) state_d = DIV_END;
            end
            DIV_END:  state_d = DIV_FREE;
            default:  state_d = DIV_FREE;
        endcase
    end

    // One restoring step plus sign correction of the step's outcome
    always_comb begin
        rem_shift = {rem_q, quo_q[DATA_W-1]};
        diff      = rem_shift - {1'b0, dvs_q};
        // Borrow out means the trial subtraction failed: keep the shifted remainder
        if (!diff[DATA_W]) begin
            rem_nx = diff[DATA_W-1:0];
            quo_nx = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
            rem_nx = rem_shift[DATA_W-1:0];
            quo_nx = {quo_q[DATA_W-2:0], 1'b0};
        end
        q_fix = neg_q_q ? (~quo_nx + DATA_W'(1)) : quo_nx;
        r_fix = neg_r_q ? (~rem_nx + DATA_W'(1)) : rem_nx;
        abs1  = (signed_div && opdata1[DATA_W-1]) ? (~opdata1 + DATA_W'(1)) : opdata1;
        abs2  = (signed_div && opdata2[DATA_W-1]) ? (~opdata2 + DATA_W'(1)) : opdata2;
    end

    // Operand latch, iteration and result capture
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            result  <= '0;
            ready   <= 1'b0;
        end else begin
            ready <= (state_d == DIV_END);
            case (state_q)
                DIV_FREE: begin
                    cnt_q <= '0;
                    if (start && !annul) begin
                        if (div_zero) begin
                            result <= '0;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= abs1;
                            dvs_q   <= abs2;
                            neg_q_q <= signed_div && (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
                            neg_r_q <= signed_div && opdata1[DATA_W-1];
                        end
                    end
                end
                DIV_ON: begin
                    if (!annul) begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_iter) result <= {r_fix, q_fix};
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

endmodule

// File: rtl/ex_div.sv
// Execute stage: combinational logic/shift/arith ALU with ADD/SUB overflow
// write suppression, plus an iterative divider for DIV/DIVU that raises a
// stall until the quotient is ready.
// Ports: clk, rst (sync, active-high); bus (ex_div_if.slave) carries the
// id/ex operation and operands in, and the GPR writeback triple, HI/LO
// write and stall request out. All outputs are forced to 0 while in reset.
module ex_div
    import ex_div_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    ex_div_if.slave bus
);

    reg_bus_t             logic_res;
    reg_bus_t             shift_res;
    reg_bus_t             arith_res;
    reg_bus_t             reg2_mux;
    reg_bus_t             sum;
    logic [4:0]           shamt;
    logic                 is_sub;
    logic                 ovf;
    logic                 div_op;
    logic                 signed_div;
    logic                 div_ready;
    logic [2*DATA_W-1:0]  div_result;
    logic                 whilo;

    assign div_op     = is_div_op(bus.aluop_i);
    assign signed_div = (bus.aluop_i == EXE_DIV_OP);

    ex_div_div u_div (
        .clk        (clk),
        .rst        (rst),
        .signed_div (signed_div),
        .opdata1    (bus.reg1_i),
        .opdata2    (bus.reg2_i),
        .start      (div_op),
        .annul      (bus.annul_i),
        .result     (div_result),
        .ready      (div_ready)
    );

    // Single-cycle ALU result classes
    always_comb begin
        shamt     = bus.reg1_i[4:0];
        is_sub    = (bus.aluop_i == EXE_SUB_OP)  || (bus.aluop_i == EXE_SUBU_OP) ||
                    (bus.aluop_i == EXE_SLT_OP)  || (bus.aluop_i == EXE_SLTU_OP);
        reg2_mux  = is_sub ? (~bus.reg2_i + DATA_W'(1)) : bus.reg2_i;
        sum       = bus.reg1_i + reg2_mux;
        // Signed overflow: same-sign addends producing an opposite-sign sum
        ovf       = ((bus.aluop_i == EXE_ADD_OP) || (bus.aluop_i == EXE_SUB_OP)) &&
                    (bus.reg1_i[DATA_W-1] == reg2_mux[DATA_W-1]) &&
                    (sum[DATA_W-1] != bus.reg1_i[DATA_W-1]);

        logic_res = ZERO_WORD;
        case (bus.aluop_i)
            EXE_OR_OP:  logic_res = bus.reg1_i | bus.reg2_i;
            EXE_AND_OP: logic_res = bus.reg1_i & bus.reg2_i;
            EXE_XOR_OP: logic_res = bus.reg1_i ^ bus.reg2_i;
            EXE_NOR_OP: logic_res = ~(bus.reg1_i | bus.reg2_i);
            default:    logic_res = ZERO_WORD;
        endcase

        shift_res = ZERO_WORD;
        case (bus.aluop_i)
            EXE_SLL_OP: shift_res = bus.reg2_i << shamt;
            EXE_SRL_OP: shift_res = bus.reg2_i >> shamt;
            EXE_SRA_OP: shift_res = reg_bus_t'($signed(bus.reg2_i) >>> shamt);
            default:    shift_res = ZERO_WORD;
        endcase

        arith_res = ZERO_WORD;
        case (bus.aluop_i)
            EXE_ADD_OP, EXE_ADDU_OP,
            EXE_SUB_OP, EXE_SUBU_OP: arith_res = sum;
            EXE_SLT_OP:  arith_res = DATA_W'($signed(bus.reg1_i) < $signed(bus.reg2_i));
            EXE_SLTU_OP: arith_res = DATA_W'(bus.reg1_i < bus.reg2_i);
            default:     arith_res = ZERO_WORD;
        endcase
    end

    // Output mux, stall and HI/LO glue; everything zero while in reset
    always_comb begin
        bus.wd_o       = '0;
        bus.wreg_o     = 1'b0;
        bus.wdata_o    = ZERO_WORD;
        bus.whilo_o    = 1'b0;
        bus.hi_o       = ZERO_WORD;
        bus.lo_o       = ZERO_WORD;
        bus.stallreq_o = 1'b0;
        whilo          = 1'b0;
        if (rst != RST_ENABLE) begin
            bus.wd_o   = bus.wd_i;
            bus.wreg_o = bus.wreg_i && !ovf;
            case (bus.alusel_i)
                EXE_RES_LOGIC: bus.wdata_o = logic_res;
                EXE_RES_SHIFT: bus.wdata_o = shift_res;
                EXE_RES_ARITH: bus.wdata_o = arith_res;
                default:       bus.wdata_o = ZERO_WORD;
            endcase
            // div_ready is high exactly in the END state
            bus.stallreq_o = div_op && !div_ready;
            whilo          = div_op && div_ready && !bus.annul_i;
            bus.whilo_o    = whilo;
            if (whilo) begin
                bus.hi_o = div_result[2*DATA_W-1:DATA_W];
                bus.lo_o = div_result[DATA_W-1:0];
            end
        end
    end

endmodule
